// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared types, widths and symmetric coefficient half for the FIR tap sequencer
package fir_pkg;

  localparam int FIR_TAPS   = 16;
  localparam int FIR_MAX_H  = 32;
  localparam int FIR_MAX_KW = 5;
  localparam int COEF_W     = 18;
  localparam int SAMPLE_W   = 16;
  localparam int P_W        = 48;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } fir_state_t;

  // Q1.17 half of a symmetric low-pass; h[0] pairs with the newest sample.
  // Entries past the default H are zero so longer builds still elaborate.
  localparam logic signed [COEF_W-1:0] FIR_COEF [0:FIR_MAX_H-1] = '{
    -18'sd512, -18'sd1024, 18'sd0, 18'sd3072, 18'sd8192, 18'sd14336, 18'sd19456, 18'sd22528,
    18'sd0, 18'sd0, 18'sd0, 18'sd0, 18'sd0, 18'sd0, 18'sd0, 18'sd0,
    18'sd0, 18'sd0, 18'sd0, 18'sd0, 18'sd0, 18'sd0, 18'sd0, 18'sd0,
    18'sd0, 18'sd0, 18'sd0, 18'sd0, 18'sd0, 18'sd0, 18'sd0, 18'sd0
  };

  function automatic logic signed [SAMPLE_W-1:0] fir_saturate(input logic signed [P_W:0] v);
    if (v > 49'sd32767)
      return 16'sh7fff;
    else if (v < -49'sd32768)
      return 16'sh8000;
    else
      return v[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/fir_coef_rom.sv
// rtl/fir_coef_rom.sv - combinational tap index to coefficient lookup
module fir_coef_rom
  import fir_pkg::*;
#(
  parameter int H  = FIR_TAPS / 2,
  parameter int KW = $clog2(H)
) (
  input  logic [KW-1:0]     k,
  output logic [COEF_W-1:0] coef
);

  assign coef = FIR_COEF[FIR_MAX_KW'(k)];

endmodule

// File: rtl/fir_tap_sequencer.sv
// rtl/fir_tap_sequencer.sv - symmetric FIR tap sequencer driving an external pre-add MAC
// Build option FIR_ROUND_EN: round half up before the output shift; otherwise truncate.
module fir_tap_sequencer
  import fir_pkg::*;
#(
  parameter int TAPS      = FIR_TAPS,
  parameter int OUT_SHIFT = 17
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [15:0]   sample_in,
  input  logic          sample_valid,
  output logic          mac_use_accum,
  output logic [17:0]   mac_a,
  output logic [17:0]   mac_d,
  output logic [17:0]   mac_b,
  input  logic [47:0]   mac_p,
  output logic [15:0]   sample_out,
  output logic          out_valid,
  output logic          busy,
  output logic          overrun
);

  localparam int H  = TAPS / 2;
  localparam int AW = $clog2(TAPS);
  localparam int KW = $clog2(H);

  fir_state_t state, next_state;

  logic [AW-1:0]              wp;
  logic [AW-1:0]              rd_d;
  logic [AW-1:0]              rd_b;
  logic [KW-1:0]              k;
  logic signed [SAMPLE_W-1:0] hist [0:TAPS-1];
  logic [COEF_W-1:0]          coef;
  logic signed [P_W:0]        p_ext;
  logic signed [P_W:0]        p_rnd;
  logic signed [P_W:0]        p_shift;
  logic signed [SAMPLE_W-1:0] p_sat;

  fir_coef_rom #(.H(H), .KW(KW)) u_coef_rom (
    .k    (k),
    .coef (coef)
  );

  assign rd_d = wp - AW'(k) - AW'(1);
  // wp-1-(TAPS-1-k) collapses to wp+k modulo TAPS
  assign rd_b = wp + AW'(k);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (sample_valid) next_state = ST_MAC;
      ST_MAC:  if (k == KW'(H - 1)) next_state = ST_OUT;
      ST_OUT:  next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    busy          = (state != ST_IDLE);
    mac_use_accum = 1'b0;
    mac_a         = '0;
    mac_d         = '0;
    mac_b         = '0;
    if (state == ST_MAC) begin
      mac_use_accum = (k != '0);
      mac_a         = coef;
      mac_d         = {{2{hist[rd_d][SAMPLE_W-1]}}, hist[rd_d]};
      mac_b         = {{2{hist[rd_b][SAMPLE_W-1]}}, hist[rd_b]};
    end
  end

  // One guard bit above P keeps the rounding add from wrapping.
  always_comb begin
    p_ext = $signed({mac_p[P_W-1], mac_p});
`ifdef FIR_ROUND_EN
    p_rnd = p_ext + ((P_W + 1)'(1) << (OUT_SHIFT - 1));
`else
    p_rnd = p_ext;
`endif
    p_shift = p_rnd >>> OUT_SHIFT;
    p_sat   = fir_saturate(p_shift);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp         <= '0;
      k          <= '0;
      sample_out <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
      for (int i = 0; i < TAPS; i++)
        hist[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      if (sample_valid && state != ST_IDLE)
        overrun <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (sample_valid) begin
            hist[wp] <= sample_in;
            wp       <= wp + AW'(1);
            k        <= '0;
          end
        end
        ST_MAC: k <= k + KW'(1);
        ST_OUT: begin
          sample_out <= p_sat;
          out_valid  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
